instr_prefetch: RTL

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch.sv | 115 +++++++++++
 1 files changed

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: issues sequential word reads, buffers
// {instr, pc} pairs and hands them to the CPU; redirect flushes and restarts.
//
// Ports:
//   clk, reset (async, active-low)
//   o_mem_addr/o_mem_rd/i_mem_rddata/o_mem_byte_en : memory read port,
//     data returns one cycle after the read strobe
//   o_instr/o_instr_pc/o_instr_valid/i_instr_ready : queue head to the CPU
//   i_redirect/i_redirect_pc : flush and restart fetch at a new address
//   o_count : number of valid queue entries
module instr_prefetch #(
    parameter int IW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [IW-1:0]          o_mem_addr,
    output logic                   o_mem_rd,
    input  logic [IW-1:0]          i_mem_rddata,
    output logic [3:0]             o_mem_byte_en,
    output logic [IW-1:0]          o_instr,
    output logic [IW-1:0]          o_instr_pc,
    output logic                   o_instr_valid,
    input  logic                   i_instr_ready,
    input  logic                   i_redirect,
    input  logic [IW-1:0]          i_redirect_pc,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [IW-1:0] fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [IW-1:0] inflight_pc_q, inflight_pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [IW-1:0] instr_q [DEPTH];
    logic [IW-1:0] pc_q    [DEPTH];

    logic [AW+1:0] occ;
    logic          issue;
    logic          enq;
    logic          deq;
    logic          unused_ok;

    // Low address bits of the redirect target are dropped (word aligned).
    assign unused_ok = ^i_redirect_pc[1:0];

    // Occupancy counts the outstanding read so the queue can never overflow.
    assign occ   = {1'b0, count_q} + {{(AW + 1){1'b0}}, inflight_q};
    assign issue = reset & ~i_redirect & (occ < (AW + 2)'(DEPTH));
    // A response landing in a redirect cycle belongs to the old stream.
    assign enq   = inflight_q & ~i_redirect;
    assign deq   = o_instr_valid & i_instr_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
        if (i_redirect) begin
            fetch_pc_d = {i_redirect_pc[IW-1:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + IW'(4);
            if (enq)   wr_ptr_d   = wr_ptr_q + AW'(1);
            if (deq)   rd_ptr_d   = rd_ptr_q + AW'(1);
            unique case ({enq, deq})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            if (enq) begin
                instr_q[wr_ptr_q] <= i_mem_rddata;
                pc_q[wr_ptr_q]    <= inflight_pc_q;
            end
        end
    end

    assign o_mem_rd      = issue;
    assign o_mem_addr    = fetch_pc_q;
    assign o_mem_byte_en = 4'b1111;
    assign o_count       = count_q;
    assign o_instr_valid = (count_q != '0) & ~i_redirect;
    assign o_instr       = o_instr_valid ? instr_q[rd_ptr_q] : '0;
    assign o_instr_pc    = o_instr_valid ? pc_q[rd_ptr_q] : '0;

endmodule
